// File: rtl/counter_register.sv
// Multi-function register: parallel load, increment/decrement, add, shifts and rotate.
// Carry holds the bit produced by the last executed operation; zero is a live flag on the register.
module counter_register #(
  parameter int unsigned             DataWidth  = 16,
  parameter logic [DataWidth-1:0]    ResetValue = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 ld_ni,
  input  logic [2:0]           op_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 carry_o,
  output logic                 zero_o
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_ROL  = 3'b111
  } op_e;

  localparam logic [DataWidth-1:0] One = {{(DataWidth-1){1'b0}}, 1'b1};

  logic [DataWidth-1:0] data_next;
  logic                 carry_next;
  logic [DataWidth:0]   sum;

  // INC and ADD share one extended adder so the carry falls out of its top bit
  always_comb begin
    data_next  = data_o;
    carry_next = carry_o;
    sum        = '0;
    unique case (op_e'(op_i))
      OP_HOLD: ;
      OP_INC: begin
        sum        = {1'b0, data_o} + {1'b0, One};
        data_next  = sum[DataWidth-1:0];
        carry_next = sum[DataWidth];
      end
      OP_DEC: begin
        data_next  = data_o - One;
        carry_next = (data_o == '0);
      end
      OP_ADD: begin
        sum        = {1'b0, data_o} + {1'b0, data_i};
        data_next  = sum[DataWidth-1:0];
        carry_next = sum[DataWidth];
      end
      OP_SHL: begin
        data_next  = {data_o[DataWidth-2:0], 1'b0};
        carry_next = data_o[DataWidth-1];
      end
      OP_SHR: begin
        data_next  = {1'b0, data_o[DataWidth-1:1]};
        carry_next = data_o[0];
      end
      OP_ASR: begin
        data_next  = {data_o[DataWidth-1], data_o[DataWidth-1:1]};
        carry_next = data_o[0];
      end
      OP_ROL: begin
        data_next  = {data_o[DataWidth-2:0], data_o[DataWidth-1]};
        carry_next = data_o[DataWidth-1];
      end
      default: ;
    endcase
  end

  // Reset beats load, load beats the selected operation
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_o  <= ResetValue;
      carry_o <= 1'b0;
    end else if (!ld_ni) begin
      data_o  <= data_i;
      carry_o <= 1'b0;
    end else begin
      data_o  <= data_next;
      carry_o <= carry_next;
    end
  end

  assign zero_o = (data_o == '0);

endmodule
